// File: rtl/rs_decode_sequencer.sv
// Frame-level sequencer for the RS(255,239) decoder: receive/syndrome control,
// KES launch, Chien/Forney output streaming and three-bank buffer rotation.
module rs_decode_sequencer #(
    parameter int N     = 255,
    parameter int K     = 239,
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             sys_rst,
    input  logic             sync,
    input  logic             in_valid,
    output logic             syn_clr,
    output logic             syn_en,
    output logic             syn_last,
    output logic [CNT_W-1:0] wr_addr,
    output logic [1:0]       wr_bank,
    output logic             kes_start,
    input  logic             kes_done,
    output logic             cs_start,
    output logic             out_valid,
    output logic             out_last,
    output logic [CNT_W-1:0] rd_addr,
    output logic [1:0]       rd_bank,
    output logic             frame_err,
    output logic             busy
);

    if (CNT_W < 1 || N > (1 << CNT_W) || K >= N) begin : g_param_error
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {KES_IDLE, KES_SOLVE, KES_PEND} kes_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_START, OUT_RUN} out_state_t;

    kes_state_t       kes_state, kes_n;
    out_state_t       out_state, out_n;
    logic             rx_active, rx_active_n;
    logic [CNT_W-1:0] rx_idx, sym_idx;
    logic [1:0]       kes_bank;
    logic             accept, abort, out_free, handoff, kes_free;
    logic             complete_ok, complete_drop;

    always_comb begin
        accept        = in_valid && (!sync || rx_active);
        abort         = in_valid && !sync && rx_active;
        sym_idx       = sync ? rx_idx : '0;
        // cs_start cycle counts as occupied so one solved frame can't launch twice
        out_free      = (out_state == OUT_IDLE) || (out_state == OUT_RUN && out_last);
        handoff       = ((kes_state == KES_PEND) || (kes_state == KES_SOLVE && kes_done)) && out_free;
        kes_free      = (kes_state == KES_IDLE) || handoff;
        complete_ok   = syn_last && kes_free;
        complete_drop = syn_last && !kes_free;
        rx_active_n   = accept ? (sym_idx != LAST) : rx_active;

        kes_n = kes_state;
        if (complete_ok)
            kes_n = KES_SOLVE;
        else if (handoff)
            kes_n = KES_IDLE;
        else if (kes_state == KES_SOLVE && kes_done)
            kes_n = KES_PEND;

        out_n = out_state;
        if (handoff)
            out_n = OUT_START;
        else if (out_state == OUT_START)
            out_n = OUT_RUN;
        else if (out_state == OUT_RUN && out_last)
            out_n = OUT_IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            rx_active <= 1'b0;
            rx_idx    <= '0;
            kes_state <= KES_IDLE;
            kes_bank  <= '0;
            out_state <= OUT_IDLE;
            syn_clr   <= 1'b0;
            syn_en    <= 1'b0;
            syn_last  <= 1'b0;
            wr_addr   <= '0;
            wr_bank   <= '0;
            kes_start <= 1'b0;
            cs_start  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_addr   <= '0;
            rd_bank   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_active <= rx_active_n;
            syn_en    <= accept;
            syn_clr   <= accept && (sym_idx == '0);
            syn_last  <= accept && (sym_idx == LAST);
            if (accept) begin
                wr_addr <= sym_idx;
                rx_idx  <= (sym_idx == LAST) ? '0 : sym_idx + 1'b1;
            end

            // A dropped frame leaves wr_bank alone so the next frame reuses the bank
            frame_err <= abort || complete_drop;
            kes_start <= complete_ok;
            if (complete_ok) begin
                kes_bank <= wr_bank;
                wr_bank  <= (wr_bank == 2'd2) ? 2'd0 : wr_bank + 2'd1;
            end
            kes_state <= kes_n;

            cs_start <= handoff;
            if (handoff)
                rd_bank <= kes_bank;
            out_state <= out_n;
            out_valid <= (out_n == OUT_RUN);
            if (out_state == OUT_START) begin
                rd_addr  <= '0;
                out_last <= (LAST == '0);
            end else if (out_state == OUT_RUN && !out_last) begin
                rd_addr  <= rd_addr + 1'b1;
                out_last <= (rd_addr == LAST - 1'b1);
            end else begin
                out_last <= 1'b0;
            end

            busy <= rx_active_n || (kes_n != KES_IDLE) || (out_n != OUT_IDLE);
        end
    end

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Directed bench for rs_decode_sequencer: timing, bank rotation, drop/abort,
// delayed handoff and reset scenarios with hand-computed cycle expectations.
module tb_rs_decode_sequencer;

    localparam int N = 255;

    logic       clk_in = 1'b0;
    logic       sys_rst, sync, in_valid, kes_done;
    logic       kes_man = 1'b0, kes_auto_pulse = 1'b0;
    logic       syn_clr, syn_en, syn_last, kes_start, cs_start;
    logic       out_valid, out_last, frame_err, busy;
    logic [7:0] wr_addr, rd_addr;
    logic [1:0] wr_bank, rd_bank;

    always #5 clk_in = ~clk_in;
    assign kes_done = kes_man | kes_auto_pulse;

    rs_decode_sequencer #(.N(255), .K(239), .CNT_W(8)) dut (
        .clk_in(clk_in), .sys_rst(sys_rst), .sync(sync), .in_valid(in_valid),
        .syn_clr(syn_clr), .syn_en(syn_en), .syn_last(syn_last),
        .wr_addr(wr_addr), .wr_bank(wr_bank), .kes_start(kes_start),
        .kes_done(kes_done), .cs_start(cs_start), .out_valid(out_valid),
        .out_last(out_last), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .frame_err(frame_err), .busy(busy)
    );

    int checks = 0, errors = 0;
    int cyc = 0, base = 0, lat = 20, kcnt = 0, kd_cyc = 0;
    bit auto_en = 1'b0;

    always @(posedge clk_in) cyc++;

    // KES stand-in: kes_done pulses 'lat' cycles after each kes_start
    always @(negedge clk_in) begin
        kes_auto_pulse = 1'b0;
        if (sys_rst) kcnt = 0;
        else begin
            if (kcnt > 0) begin
                kcnt--;
                if (kcnt == 0) kes_auto_pulse = 1'b1;
            end
            if (kes_start && auto_en) kcnt = lat;
        end
    end

    int ferr_q[$], ks_q[$], ks_wb[$], cs_q[$], cs_rb[$], sl_q[$];
    int st_start[$], st_end[$], st_bank[$], st_wb[$], st_len[$];
    int stream_bad = 0, bank_bad = 0, exp_a = 0;
    bit in_st = 1'b0;
    logic [1:0] cur_b = '0;

    always @(negedge clk_in) begin
        if (frame_err) ferr_q.push_back(cyc);
        if (syn_last)  sl_q.push_back(cyc);
        if (kes_start) begin ks_q.push_back(cyc); ks_wb.push_back(int'(wr_bank)); end
        if (cs_start)  begin cs_q.push_back(cyc); cs_rb.push_back(int'(rd_bank)); end
        if (syn_en && out_valid && wr_bank == rd_bank) bank_bad++;
        if (out_last && !out_valid) stream_bad++;
        if (out_valid) begin
            if (!in_st) begin
                in_st = 1'b1; exp_a = 0; cur_b = rd_bank;
                st_start.push_back(cyc); st_bank.push_back(int'(rd_bank));
                st_wb.push_back(int'(wr_bank));
            end
            if (int'(rd_addr) != exp_a || rd_bank != cur_b || out_last != (exp_a == N - 1))
                stream_bad++;
            exp_a++;
            if (out_last) begin
                in_st = 1'b0; st_end.push_back(cyc); st_len.push_back(exp_a);
            end
        end else in_st = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic clear_logs();
        ferr_q.delete(); ks_q.delete(); ks_wb.delete(); cs_q.delete(); cs_rb.delete();
        sl_q.delete(); st_start.delete(); st_end.delete(); st_bank.delete();
        st_wb.delete(); st_len.delete(); stream_bad = 0; bank_bad = 0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; sync = 1'b1; in_valid = 1'b0; kes_man = 1'b0;
        step();
        clear_logs();
        sys_rst = 1'b0;
    endtask

    task automatic send_syms(input int n, input bit start, input int kd_at = -1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            sync     = !(start && i == 0);
            kes_man  = (i == kd_at);
            step();
        end
        kes_man = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0; sync = 1'b1;
    endtask

    task automatic wait_streams(input int n, input int limit);
        for (int i = 0; i < limit && st_end.size() < n; i++) step();
        chk("stream_timeout", st_end.size() >= n, 1);
        step(2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {syn_clr, syn_en, syn_last, kes_start, cs_start,
                              out_valid, out_last, frame_err, busy}, 0);
        chk({tag, "_addrs"}, {wr_addr, rd_addr}, 0);
        chk({tag, "_banks"}, {wr_bank, rd_bank}, 0);
    endtask

    initial begin
        // 1: single clean frame, KES latency 20
        do_reset();
        chk_all_zero("reset");
        auto_en = 1'b1; lat = 20; base = cyc;
        send_syms(1, 1'b1);
        chk("f1_syn_clr", syn_clr, 1);
        chk("f1_syn_en", syn_en, 1);
        chk("f1_wr_addr0", wr_addr, 0);
        chk("f1_busy", busy, 1);
        send_syms(254, 1'b0);
        idle();
        wait_streams(1, 1000);
        chk("f1_syn_last_cyc", sl_q[0] - base, 255);
        chk("f1_kes_start_cyc", ks_q[0] - base, 256);
        chk("f1_cs_start_cyc", cs_q[0] - base, 277);
        chk("f1_out_start_cyc", st_start[0] - base, 278);
        chk("f1_out_len", st_len[0], 255);
        chk("f1_rd_bank", st_bank[0], 0);
        chk("f1_wr_bank", st_wb[0], 1);
        chk("f1_stream_ok", stream_bad, 0);
        chk("f1_no_ferr", ferr_q.size(), 0);
        chk("f1_idle_busy", busy, 0);

        // 2: three back-to-back frames, KES latency 100
        do_reset();
        lat = 100; base = cyc;
        repeat (3) send_syms(255, 1'b1);
        idle();
        wait_streams(3, 2000);
        chk("b2b_no_ferr", ferr_q.size(), 0);
        chk("b2b_wb0", ks_wb[0], 1);
        chk("b2b_wb1", ks_wb[1], 2);
        chk("b2b_wb2", ks_wb[2], 0);
        chk("b2b_rb0", st_bank[0], 0);
        chk("b2b_rb1", st_bank[1], 1);
        chk("b2b_rb2", st_bank[2], 2);
        chk("b2b_ks1_cyc", ks_q[1] - base, 511);
        chk("b2b_cs1_cyc", cs_q[1] - base, 613);
        chk("b2b_gap01", st_start[1] - st_end[0], 2);
        chk("b2b_gap12", st_start[2] - st_end[1], 2);
        chk("b2b_stream_ok", stream_bad, 0);
        chk("b2b_bank_safe", bank_bad, 0);

        // 3: KES latency 400, second frame dropped, third reuses its bank
        do_reset();
        lat = 400; base = cyc;
        repeat (3) send_syms(255, 1'b1);
        idle();
        wait_streams(2, 2500);
        chk("drop_ferr_cnt", ferr_q.size(), 1);
        chk("drop_ferr_cyc", ferr_q[0] - base, 511);
        chk("drop_ks_cnt", ks_q.size(), 2);
        chk("drop_ks1_cyc", ks_q[1] - base, 766);
        chk("drop_ks1_wb", ks_wb[1], 2);
        chk("drop_cs1_cyc", cs_q[1] - base, 1167);
        chk("drop_rb1", st_bank[1], 1);
        chk("drop_stream_ok", stream_bad, 0);

        // 4: resync at symbol index 100
        do_reset();
        lat = 20; base = cyc;
        send_syms(100, 1'b1);
        in_valid = 1'b1; sync = 1'b0;
        step();
        chk("abort_ferr", frame_err, 1);
        chk("abort_syn_clr", syn_clr, 1);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_wr_bank", wr_bank, 0);
        send_syms(254, 1'b0);
        idle();
        wait_streams(1, 1000);
        chk("abort_ferr_cnt", ferr_q.size(), 1);
        chk("abort_ks_cyc", ks_q[0] - base, 356);
        chk("abort_rb", st_bank[0], 0);
        chk("abort_len", st_len[0], 255);

        // 5: stray kes_done, then kes_done mid-stream held until out_last
        do_reset();
        auto_en = 1'b0;
        kes_man = 1'b1;
        step();
        kes_man = 1'b0;
        step(3);
        chk("stray_cs", cs_q.size(), 0);
        chk("stray_busy", busy, 0);
        base = cyc;
        send_syms(255, 1'b1);
        send_syms(255, 1'b1, 245);
        idle();
        for (int i = 0; i < 1000 && !(out_valid && rd_addr == 8'd50); i++) step();
        kd_cyc = cyc;
        kes_man = 1'b1;
        step();
        kes_man = 1'b0;
        wait_streams(2, 1500);
        chk("hold_kd_cyc", kd_cyc - base, 552);
        chk("hold_cs0_cyc", cs_q[0] - base, 501);
        chk("hold_end0_cyc", st_end[0] - base, 756);
        chk("hold_cs1_after_last", cs_q[1] - st_end[0], 1);
        chk("hold_cs1_rb", cs_rb[1], 1);
        chk("hold_rb0", st_bank[0], 0);
        chk("hold_rb1", st_bank[1], 1);
        chk("hold_stream_ok", stream_bad, 0);
        chk("hold_no_ferr", ferr_q.size(), 0);

        // 6: reset mid-stream and mid-frame, then a fresh frame
        do_reset();
        auto_en = 1'b1; lat = 20;
        send_syms(255, 1'b1);
        send_syms(60, 1'b1);
        chk("mid_out_valid", out_valid, 1);
        chk("mid_syn_en", syn_en, 1);
        sys_rst = 1'b1; in_valid = 1'b0; sync = 1'b1;
        step();
        sys_rst = 1'b0;
        chk_all_zero("midrst");
        step(3);
        chk("midrst_quiet", {busy, frame_err, cs_start, kes_start}, 0);
        clear_logs();
        base = cyc;
        send_syms(255, 1'b1);
        idle();
        wait_streams(1, 1000);
        chk("fresh_ks_cyc", ks_q[0] - base, 256);
        chk("fresh_cs_cyc", cs_q[0] - base, 277);
        chk("fresh_rb", st_bank[0], 0);
        chk("fresh_wb", st_wb[0], 1);
        chk("fresh_no_ferr", ferr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rs_decode_sequencer.md
Name: rs_decode_sequencer

Overview:
- Frame-level controller for the RS(255,239) decoder datapath.
- Tracks received codeword symbols and drives the syndrome stage enables and buffer write addresses.
- Launches the key-equation solver (KES) and the Chien/Forney output stream.
- Rotates three codeword buffer banks so receive, solve and output can each hold one frame concurrently.

Parameters:
- N, 255, codeword length in symbols.
- K, 239, message length in symbols; informational, no logic depends on it.
- CNT_W, 8, symbol counter/address width; must satisfy 2^CNT_W >= N.

Ports:
- clk_in  input  1  system clock
- sys_rst  input  1  synchronous reset, active-high
- sync  input  1  frame sync, active-low; low with in_valid marks symbol 0
- in_valid  input  1  a received symbol is present this cycle
- syn_clr  output  1  clear syndrome accumulators (with symbol 0)
- syn_en  output  1  accumulate current symbol into syndromes
- syn_last  output  1  final symbol of frame
- wr_addr  output  CNT_W  buffer write address
- wr_bank  output  2  buffer bank being written (0..2)
- kes_start  output  1  one-cycle pulse: syndromes valid, start KES
- kes_done  input  1  one-cycle pulse from KES: locator/evaluator ready
- cs_start  output  1  one-cycle pulse: start Chien/Forney pass
- out_valid  output  1  corrected symbol valid this cycle
- out_last  output  1  final corrected symbol
- rd_addr  output  CNT_W  buffer read address
- rd_bank  output  2  bank being read
- frame_err  output  1  one-cycle pulse: frame dropped or aborted
- busy  output  1  any stage occupied

Behaviour:
- Reset (synchronous, sys_rst=1): all outputs 0; wr_bank=0; rd_bank=0; all stages idle. Reset mid-operation aborts every frame with no frame_err.
- RX stage:
  - Symbol accepted when in_valid=1 and either sync=0 or RX is active. in_valid with sync=1 while RX idle is ignored.
  - sync=0 with in_valid starts a frame at index 0.
  - sync=0 with in_valid while RX is active (index>0) aborts the partial frame, pulses frame_err, and restarts at index 0 in the same bank.
  - All RX outputs are registered, 1 cycle after acceptance: syn_en=1; wr_addr=index; syn_clr=1 iff index==0; syn_last=1 iff index==N-1.
  - Gaps (in_valid=0) mid-frame hold the index; no timeout.
  - After index N-1, RX returns to idle.
- Frame completion, evaluated in the cycle syn_last is high:
  - KES free: kes_start pulses on the next cycle; the frame's bank moves to the KES stage; wr_bank advances 0->1->2->0 in the same cycle as kes_start.
  - KES occupied: frame_err pulses on the next cycle; frame dropped; wr_bank unchanged (bank reused).
- KES stage:
  - Occupied from kes_start until it hands off to OUT.
  - kes_done received while KES idle is ignored.
  - After kes_done, the stage holds "pending" until OUT is free.
- OUT stage handoff:
  - OUT counts as free in a cycle where it is idle, or where it asserts out_last.
  - When pending and OUT is free, cs_start pulses on the next cycle and rd_bank takes the KES bank.
  - If kes_done arrives while OUT is free, cs_start is exactly 1 cycle after kes_done.
- OUT stream:
  - Starts the cycle after cs_start; out_valid=1 for exactly N consecutive cycles.
  - rd_addr counts 0..N-1; out_last=1 with rd_addr=N-1; rd_bank held for the whole stream.
  - Back-to-back frames: out_last at t, cs_start at t+1, out_valid resumes at t+2.
- Bank safety: RX, KES and OUT each own a distinct bank at all times; a written bank is never the current rd_bank.
- busy = RX active OR KES occupied OR OUT streaming (registered).
- Simultaneous kes_done and syn_last: the handoff of the KES frame to OUT occurs first. The KES stage is then free, so the new frame is accepted (no frame_err).

Test Plan:
- One clean frame: sync low with symbol 0, then 255 contiguous symbols; kes_done 20 cycles after kes_start -> syn_clr at cycle 1, syn_last at cycle 255, kes_start at 256, cs_start 1 cycle after kes_done. Then 255 out_valid cycles with rd_bank=0 and wr_bank=1.
- Three back-to-back frames with KES latency 100 cycles -> no frame_err. wr_bank sequence 0,1,2,0; rd_bank 0,1,2; out_valid streams separated by exactly one idle cycle where OUT-limited.
- KES latency 400 cycles, frames back-to-back -> frame 2 completes while KES is busy: frame_err pulse 1 cycle after its syn_last, wr_bank unchanged, frame 3 reuses that bank.
- sync low again at symbol index 100 -> frame_err pulse, syn_clr reasserted, wr_addr restarts at 0, bank unchanged. The following full frame decodes normally.
- kes_done arrives while OUT is at rd_addr 50 -> cs_start held until 1 cycle after out_last, rd_bank switches only then. Also: a stray kes_done while idle produces no response.
- sys_rst=1 for 1 cycle mid OUT stream and mid RX -> next cycle all outputs 0, banks 0, busy 0. A fresh frame afterwards behaves as in the first test.
